// File: rtl/pool_pkg.sv
// Shared constants, FSM state encoding and source-map helper for the pooling engine.
package pool_pkg;

   localparam int DEFAULT_BIT_DEPTH = 8;
   localparam int MAP_DIM           = 6;
   localparam int POS_W             = 3;
   localparam int ADDR_W            = 5;

   // Stride decode: only 2'b10 selects stride 2, every other code is stride 1.
   localparam logic [1:0]       STRIDE_2_CODE = 2'b10;
   localparam logic [POS_W-1:0] STEP_1        = 3'd1;
   localparam logic [POS_W-1:0] STEP_2        = 3'd2;
   localparam logic [POS_W-1:0] LAST_ORIGIN   = 3'(MAP_DIM - 2);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      COMBINE,
      WRITE,
      DONE
   } pool_state_t;

   // Constant source feature map contents: src[r][c] = 6*r + c.
   function automatic int src_pixel(input int r, input int c);
      return r * MAP_DIM + c;
   endfunction

endpackage

// File: rtl/pool_alu.sv
// Combinational two-operand reducer: max, truncated average, or pass x.
module pool_alu
   import pool_pkg::*;
#(
   parameter int BIT_DEPTH = DEFAULT_BIT_DEPTH
) (
   input  logic [BIT_DEPTH-1:0] x,
   input  logic [BIT_DEPTH-1:0] y,
   input  logic                 pool_type,
   input  logic                 pool_en,
   output logic [BIT_DEPTH-1:0] result
);

   logic [BIT_DEPTH:0] pair_sum;

   // Sum carries one extra bit so the halved average never overflows.
   assign pair_sum = {1'b0, x} + {1'b0, y};

   // Select the reduction for the latched mode.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      result = x;
      if (pool_en) begin
         if (pool_type) result = (x > y) ? x : y;
         else           result = pair_sum[BIT_DEPTH:1];
      end
   end

endmodule

// File: rtl/pool_top.sv
// 2x2 pooling engine: scans the 6x6 source map, reduces each window and writes it out.
module pool_top
   import pool_pkg::*;
#(
   parameter int BIT_DEPTH = DEFAULT_BIT_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 pool_type,
   input  logic                 pool_en,
   input  logic [1:0]           stride,
   output logic                 shift_buffer,
   output logic                 done,
   output logic [BIT_DEPTH-1:0] sum1,
   output logic [BIT_DEPTH-1:0] sum2,
   output logic [BIT_DEPTH-1:0] sum_out,
   output logic [ADDR_W-1:0]    out_dest_addr,
   output logic                 dest_wr_en,
   output logic                 rd_data
);

   pool_state_t state, next_state;

   logic [BIT_DEPTH-1:0] src_map [MAP_DIM][MAP_DIM];

   logic                 pool_type_q;
   logic                 pool_en_q;
   logic                 stride2_q;
   logic [POS_W-1:0]     row;
   logic [POS_W-1:0]     col;
   logic [POS_W-1:0]     row_below;
   logic [POS_W-1:0]     col_right;
   logic [POS_W-1:0]     step;
   logic [ADDR_W-1:0]    dest_idx;
   logic                 last_col;
   logic                 last_row;

   logic [BIT_DEPTH-1:0] pix_a, pix_b, pix_c, pix_d;
   logic [BIT_DEPTH-1:0] top_res, bot_res, win_res;

   // The source map is fixed wiring, read four pixels at a time.
   for (genvar gr = 0; gr < MAP_DIM; gr++) begin : g_row
      for (genvar gc = 0; gc < MAP_DIM; gc++) begin : g_col
         assign src_map[gr][gc] = BIT_DEPTH'(src_pixel(gr, gc));
      end
   end

   assign step      = stride2_q ? STEP_2 : STEP_1;
   assign row_below = row + STEP_1;
   assign col_right = col + STEP_1;
   assign last_col  = (col == LAST_ORIGIN);
   assign last_row  = (row == LAST_ORIGIN);

   pool_alu #(.BIT_DEPTH(BIT_DEPTH)) u_alu_top (
      .x(pix_a), .y(pix_b), .pool_type(pool_type_q), .pool_en(pool_en_q), .result(top_res)
   );

   pool_alu #(.BIT_DEPTH(BIT_DEPTH)) u_alu_bot (
      .x(pix_c), .y(pix_d), .pool_type(pool_type_q), .pool_en(pool_en_q), .result(bot_res)
   );

   pool_alu #(.BIT_DEPTH(BIT_DEPTH)) u_alu_win (
      .x(top_res), .y(bot_res), .pool_type(pool_type_q), .pool_en(pool_en_q), .result(win_res)
   );

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // Next-state decode and per-state strobes.
   always_comb begin
      next_state   = state;
      rd_data      = 1'b0;
      dest_wr_en   = 1'b0;
      shift_buffer = 1'b0;
      done         = 1'b0;
      unique case (state)
         IDLE:    if (start) next_state = READ;
         READ: begin
            rd_data    = 1'b1;
            next_state = COMBINE;
         end
         COMBINE: next_state = WRITE;
         WRITE: begin
            dest_wr_en   = 1'b1;
            shift_buffer = last_col && !last_row;
            next_state   = (last_col && last_row) ? DONE : READ;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Mode latch, window position, pixel capture and result registers.
   always_ff @(posedge clk) begin
      // NOTE: the source map is constant wiring and needs no reset; every register seen on a port is cleared.
      if (!rst) begin
         pool_type_q   <= 1'b0;
         pool_en_q     <= 1'b0;
         stride2_q     <= 1'b0;
         row           <= '0;
         col           <= '0;
         dest_idx      <= '0;
         pix_a         <= '0;
         pix_b         <= '0;
         pix_c         <= '0;
         pix_d         <= '0;
         sum1          <= '0;
         sum2          <= '0;
         sum_out       <= '0;
         out_dest_addr <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  pool_type_q <= pool_type;
                  pool_en_q   <= pool_en;
                  stride2_q   <= (stride == STRIDE_2_CODE);
                  row         <= '0;
                  col         <= '0;
                  dest_idx    <= '0;
               end
            end
            READ: begin
               pix_a <= src_map[row][col];
               pix_b <= src_map[row][col_right];
               pix_c <= src_map[row_below][col];
               pix_d <= src_map[row_below][col_right];
            end
            COMBINE: begin
               // sum_out is loaded together with the row pairs so it is valid alongside dest_wr_en.
               sum1          <= top_res;
               sum2          <= bot_res;
               sum_out       <= win_res;
               out_dest_addr <= dest_idx;
            end
            WRITE: begin
               dest_idx <= dest_idx + 5'd1;
               if (last_col) begin
                  col <= '0;
                  row <= row + step;
               end else begin
                  col <= col + step;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pool_top.sv
// Self-checking bench for pool_top: table of pass configurations plus reset corner cases.
module tb_pool_top;

   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          pool_type;
   logic          pool_en;
   logic [1:0]    stride;
   logic          shift_buffer;
   logic          done;
   logic [BW-1:0] sum1, sum2, sum_out;
   logic [4:0]    out_dest_addr;
   logic          dest_wr_en;
   logic          rd_data;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      int addr;
      int s1;
      int s2;
      int so;
   } sb_entry_t;

   typedef struct {
      logic [1:0] st;
      logic       pt;
      logic       pe;
      int         glitch_cyc;
      int         exp_writes;
      int         exp_latency;
      int         exp_shifts;
   } vec_t;

   sb_entry_t exp_q[$];
   vec_t      table_v[8];

   pool_top #(.BIT_DEPTH(BW)) dut (
      .clk(clk), .rst(rst), .start(start), .pool_type(pool_type), .pool_en(pool_en),
      .stride(stride), .shift_buffer(shift_buffer), .done(done), .sum1(sum1), .sum2(sum2),
      .sum_out(sum_out), .out_dest_addr(out_dest_addr), .dest_wr_en(dest_wr_en), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected window results in closed form from the origin pixel a = 6r + c.
   function automatic sb_entry_t model(input int r, input int c, input int idx,
                                       input logic pt, input logic pe);
      sb_entry_t e;
      int a;
      a = 6 * r + c;
      e.addr = idx;
      if (!pe) begin
         e.s1 = a;     e.s2 = a + 6; e.so = a;
      end else if (pt) begin
         e.s1 = a + 1; e.s2 = a + 7; e.so = a + 7;
      end else begin
         e.s1 = a;     e.s2 = a + 6; e.so = a + 3;
      end
      return e;
   endfunction

   task automatic run_pass(input vec_t v);
      sb_entry_t e;
      int n, step, cyc, writes, shifts;
      bit seen_done;
      int last_so;
      exp_q.delete();
      n    = (v.st == 2'b10) ? 3 : 5;
      step = (v.st == 2'b10) ? 2 : 1;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++)
            exp_q.push_back(model(i * step, j * step, i * n + j, v.pt, v.pe));
      last_so = -1;

      @(negedge clk);
      start = 1'b1; stride = v.st; pool_type = v.pt; pool_en = v.pe;
      @(posedge clk);
      @(negedge clk);
      // Scramble the mode inputs: the pass must use the latched copies.
      start = 1'b0; stride = ~v.st; pool_type = ~v.pt; pool_en = ~v.pe;
      cyc = 1;
      check("first_read", rd_data, 1);
      writes = 0; shifts = 0; seen_done = 0;
      while (!seen_done && cyc < 200) begin
         if (dest_wr_en) begin
            check("write_phase", cyc % 3, 0);
            if (exp_q.size() == 0) begin
               check("unexpected_write", dest_wr_en, 0);
            end else begin
               e = exp_q.pop_front();
               check("addr", out_dest_addr, e.addr);
               check("sum1", sum1, e.s1);
               check("sum2", sum2, e.s2);
               check("sum_out", sum_out, e.so);
               last_so = e.so;
            end
            writes++;
         end
         if (shift_buffer) shifts++;
         if (cyc == v.glitch_cyc) begin
            start  = 1'b1;
            stride = (v.st == 2'b10) ? 2'b01 : 2'b10;
         end else begin
            start = 1'b0;
         end
         if (done) seen_done = 1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      check("done_latency", cyc, v.exp_latency);
      check("write_count", writes, v.exp_writes);
      check("shift_pulses", shifts, v.exp_shifts);
      check("queue_drained", exp_q.size(), 0);

      // Start presented during DONE must be ignored.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_one_cycle", done, 0);
      check("start_in_done_rd", rd_data, 0);
      @(negedge clk);
      check("idle_after_done_rd", rd_data, 0);
      check("sum_out_hold", sum_out, last_so);
      check("addr_hold", out_dest_addr, n * n - 1);
   endtask

   initial begin
      table_v[0] = '{st: 2'b01, pt: 1'b1, pe: 1'b1, glitch_cyc: 0,  exp_writes: 25, exp_latency: 76, exp_shifts: 4};
      table_v[1] = '{st: 2'b01, pt: 1'b0, pe: 1'b1, glitch_cyc: 0,  exp_writes: 25, exp_latency: 76, exp_shifts: 4};
      table_v[2] = '{st: 2'b10, pt: 1'b1, pe: 1'b1, glitch_cyc: 0,  exp_writes: 9,  exp_latency: 28, exp_shifts: 2};
      table_v[3] = '{st: 2'b00, pt: 1'b1, pe: 1'b0, glitch_cyc: 0,  exp_writes: 25, exp_latency: 76, exp_shifts: 4};
      table_v[4] = '{st: 2'b11, pt: 1'b0, pe: 1'b1, glitch_cyc: 20, exp_writes: 25, exp_latency: 76, exp_shifts: 4};
      table_v[5] = '{st: 2'b10, pt: 1'b0, pe: 1'b1, glitch_cyc: 10, exp_writes: 9,  exp_latency: 28, exp_shifts: 2};
      table_v[6] = '{st: 2'b10, pt: 1'b0, pe: 1'b0, glitch_cyc: 0,  exp_writes: 9,  exp_latency: 28, exp_shifts: 2};
      table_v[7] = '{st: 2'b00, pt: 1'b1, pe: 1'b1, glitch_cyc: 40, exp_writes: 25, exp_latency: 76, exp_shifts: 4};

      rst = 1'b0; start = 1'b0; pool_type = 1'b0; pool_en = 1'b0; stride = 2'b00;

      // Reset held for 5 cycles clears every output.
      repeat (5) @(negedge clk);
      check("reset_outputs", {shift_buffer, done, sum1, sum2, sum_out, out_dest_addr, dest_wr_en, rd_data}, 0);

      // Start while reset is asserted does nothing.
      start = 1'b1; pool_type = 1'b1; pool_en = 1'b1;
      repeat (2) @(negedge clk);
      check("start_in_reset_rd", rd_data, 0);
      start = 1'b0;
      @(negedge clk);
      check("start_in_reset_outputs", {shift_buffer, done, sum1, sum2, sum_out, out_dest_addr, dest_wr_en, rd_data}, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_reset_rd", rd_data, 0);

      for (int k = 0; k < 8; k++) run_pass(table_v[k]);

      // Reset in the middle of a pass aborts it with zeroed outputs and no done.
      @(negedge clk);
      start = 1'b1; stride = 2'b01; pool_type = 1'b1; pool_en = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      check("midpass_busy_before_reset", sum_out != 0, 1);
      rst = 1'b0;
      @(negedge clk);
      check("midpass_reset_outputs", {shift_buffer, done, sum1, sum2, sum_out, out_dest_addr, dest_wr_en, rd_data}, 0);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("no_activity_after_abort", {done, dest_wr_en, rd_data}, 0);
      end

      // A fresh start after the abort runs a full clean pass.
      run_pass(table_v[0]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
